// File: rtl/i2c_rx_pkg.sv
// rtl/i2c_rx_pkg.sv - shared types and constants for the i2c target receiver
package i2c_rx_pkg;

    localparam int ADDR_WIDTH_DEF = 7;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        DATA,
        ACK_D,
        EXEC,
        RDWAIT
    } rx_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - two-flop synchronizer with rise/fall detect for one serial line
module i2c_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-stage synchronizer plus one history flop for edge detection; idle bus level is 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - i2c target that decodes address/R_W/data frames into memory strobes
module i2c_target_rx
    import i2c_rx_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  SCL,
    input  logic                  SDA_OUT,
    output logic                  ack_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done
);

    // Address phase carries the R_W bit as its last sampled bit
    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_e state, next_state;

    logic                  scl_s, scl_rise, scl_fall;
    logic                  sda_s, sda_rise, sda_fall;
    logic                  start_cond, stop_cond;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [ADDR_WIDTH:0]   addr_sr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic                  rw_q;
    logic                  ack_phase;
    logic                  start_pend;
    logic                  ack_n_d;
    logic                  ack_slot_end;

    i2c_sync_edge u_scl_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SCL),
        .sync    (scl_s),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SDA_OUT),
        .sync    (sda_s),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    // sSCL high now and not just risen means it was also high the previous cycle
    assign start_cond   = sda_fall && scl_s && !scl_rise;
    assign stop_cond    = sda_rise && scl_s && !scl_rise;
    // The first falling edge in an ACK state opens the slot, the second one closes it
    assign ack_slot_end = scl_fall && ack_phase;

    assign mem_we = (state == EXEC) && !rw_q;
    assign mem_re = (state == EXEC) && rw_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state decode and the acknowledge level for the coming cycle
    always_comb begin
        next_state = state;
        ack_n_d    = 1'b1;
        unique case (state)
            IDLE:   if (start_cond || start_pend) next_state = ADDR;
            ADDR: begin
                if (start_cond)                              next_state = ADDR;
                else if (stop_cond)                          next_state = IDLE;
                else if (scl_rise && bit_cnt == ADDR_LAST)   next_state = ACK_A;
            end
            ACK_A: begin
                if (start_cond)        next_state = ADDR;
                else if (stop_cond)    next_state = IDLE;
                else if (ack_slot_end) next_state = addr_sr[0] ? EXEC : DATA;
            end
            DATA: begin
                if (start_cond)                              next_state = ADDR;
                else if (stop_cond)                          next_state = IDLE;
                else if (scl_rise && bit_cnt == DATA_LAST)   next_state = ACK_D;
            end
            ACK_D: begin
                if (start_cond)        next_state = ADDR;
                else if (stop_cond)    next_state = IDLE;
                else if (ack_slot_end) next_state = EXEC;
            end
            EXEC:   next_state = rw_q ? RDWAIT : IDLE;
            RDWAIT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if ((next_state == ACK_A || next_state == ACK_D) && next_state == state
            && (ack_phase || scl_fall))
            ack_n_d = 1'b0;
    end

    // Datapath: bit counter, shift registers, captured address/data, handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            addr_sr    <= '0;
            data_sr    <= '0;
            rw_q       <= 1'b0;
            ack_phase  <= 1'b0;
            start_pend <= 1'b0;
            ack_n      <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            data_out   <= '0;
            done       <= 1'b0;
        end else begin
            if ((next_state == ADDR && (state != ADDR || start_cond)) ||
                (next_state == DATA && state != DATA))
                bit_cnt <= '0;
            else if (scl_rise && (state == ADDR || state == DATA))
                bit_cnt <= bit_cnt + CNT_WIDTH'(1);

            if (state == ADDR && scl_rise)
                addr_sr <= {addr_sr[ADDR_WIDTH-1:0], sda_s};
            if (state == DATA && scl_rise)
                data_sr <= {data_sr[DATA_WIDTH-2:0], sda_s};

            if (state == ACK_A || state == ACK_D) begin
                if (scl_fall) ack_phase <= 1'b1;
            end else begin
                ack_phase <= 1'b0;
            end

            if (state == ACK_A && ack_slot_end && !start_cond && !stop_cond) begin
                mem_addr <= addr_sr[ADDR_WIDTH:1];
                rw_q     <= addr_sr[0];
            end
            if (state == ACK_D && ack_slot_end && !start_cond && !stop_cond)
                mem_wdata <= data_sr;

            // Bus conditions during the access window are deferred until IDLE
            if (state == EXEC || state == RDWAIT) begin
                if (start_cond)     start_pend <= 1'b1;
                else if (stop_cond) start_pend <= 1'b0;
            end else if (state == IDLE) begin
                start_pend <= 1'b0;
            end

            if (state == RDWAIT) data_out <= mem_rdata;

            ack_n <= ack_n_d;
            done  <= (state == EXEC && !rw_q) || (state == RDWAIT);
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - directed self-checking bench for i2c_target_rx
module tb_i2c_target_rx;
    import i2c_rx_pkg::*;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       SCL = 1'b1;
    logic       SDA_OUT = 1'b1;
    logic       ack_n;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata = 8'hEE;
    logic [7:0] data_out;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         we_cnt = 0, re_cnt = 0, done_cnt = 0, ack_lows = 0;
    int         we_cyc = 0, done_cyc = 0;
    logic [6:0] we_addr = '0, re_addr = '0;
    logic [7:0] we_data = '0, done_dout = '0;
    logic [7:0] rd_value = 8'h00;
    logic       re_d = 1'b0;
    logic       ack_q = 1'b1;
    logic [14:0] we_log[$];

    int b_we, b_re, b_done, b_ack;

    i2c_target_rx #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .SCL       (SCL),
        .SDA_OUT   (SDA_OUT),
        .ack_n     (ack_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .data_out  (data_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        mem_rdata = re_d ? rd_value : 8'hEE;
        re_d = mem_re;
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_wdata;
            we_cyc  = cyc;
            we_log.push_back({mem_addr, mem_wdata});
        end
        if (mem_re) begin
            re_cnt++;
            re_addr = mem_addr;
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_dout = data_out;
        end
        if (!ack_n && ack_q) ack_lows++;
        ack_q = ack_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        SDA_OUT = 1'b1; wq(Q);
        SCL = 1'b1;     wq(Q);
        SDA_OUT = 1'b0; wq(Q);
        SCL = 1'b0;     wq(Q);
    endtask

    task automatic i2c_stop();
        SDA_OUT = 1'b0; wq(Q);
        SCL = 1'b1;     wq(Q);
        SDA_OUT = 1'b1; wq(4 * Q);
    endtask

    task automatic send_bit(input logic b);
        SDA_OUT = b; wq(Q);
        SCL = 1'b1;  wq(2 * Q);
        SCL = 1'b0;  wq(Q);
    endtask

    task automatic ack_slot();
        SDA_OUT = 1'b1; wq(Q);
        SCL = 1'b1;     wq(2 * Q);
        SCL = 1'b0;     wq(Q);
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rw);
        for (int i = 6; i >= 0; i--) send_bit(a[i]);
        send_bit(rw);
    endtask

    task automatic write_frame(input logic [6:0] a, input logic [7:0] d);
        i2c_start();
        send_addr(a, 1'b0);
        ack_slot();
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        ack_slot();
        i2c_stop();
    endtask

    task automatic snap();
        b_we = we_cnt; b_re = re_cnt; b_done = done_cnt; b_ack = ack_lows;
    endtask

    initial begin
        wq(4);
        chk("reset_ack_n", ack_n, 1);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_re", mem_re, 0);
        chk("reset_done", done, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_data_out", data_out, 0);
        reset_n = 1'b1;
        wq(4 * Q);

        // write 7'h15 <- 8'hA5
        snap();
        write_frame(7'h15, 8'hA5);
        chk("wr_we_count", we_cnt - b_we, 1);
        chk("wr_addr", we_addr, 7'h15);
        chk("wr_data", we_data, 8'hA5);
        chk("wr_done_count", done_cnt - b_done, 1);
        chk("wr_done_latency", done_cyc - we_cyc, 1);
        chk("wr_ack_slots", ack_lows - b_ack, 2);
        chk("wr_re_count", re_cnt - b_re, 0);

        // read 7'h7F, memory returns 8'h3C
        snap();
        rd_value = 8'h3C;
        i2c_start();
        send_addr(7'h7F, 1'b1);
        ack_slot();
        wq(4 * Q);
        i2c_stop();
        chk("rd_re_count", re_cnt - b_re, 1);
        chk("rd_addr", re_addr, 7'h7F);
        chk("rd_we_count", we_cnt - b_we, 0);
        chk("rd_done_count", done_cnt - b_done, 1);
        chk("rd_data_at_done", done_dout, 8'h3C);
        chk("rd_data_out", data_out, 8'h3C);
        chk("rd_ack_slots", ack_lows - b_ack, 1);

        // abort: STOP after 4 data bits of a write to 7'h01
        snap();
        i2c_start();
        send_addr(7'h01, 1'b0);
        ack_slot();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        chk("abort_we_count", we_cnt - b_we, 0);
        chk("abort_done_count", done_cnt - b_done, 0);
        chk("abort_ack_n", ack_n, 1);
        chk("abort_idle", dut.state === IDLE, 1);
        chk("abort_data_out_held", data_out, 8'h3C);

        // repeated START after 5 address bits, then write 7'h00 <- 8'hFF
        snap();
        i2c_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        write_frame(7'h00, 8'hFF);
        chk("rs_we_count", we_cnt - b_we, 1);
        chk("rs_addr", we_addr, 7'h00);
        chk("rs_data", we_data, 8'hFF);
        chk("rs_done_count", done_cnt - b_done, 1);

        // reset pulse mid-DATA, rest of that frame ignored, then write 7'h2B <- 8'h5A
        snap();
        i2c_start();
        send_addr(7'h2B, 1'b0);
        ack_slot();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        reset_n = 1'b0;
        wq(2);
        chk("rst_ack_n", ack_n, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_data_out", data_out, 0);
        reset_n = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        ack_slot();
        i2c_stop();
        chk("rst_first_we_count", we_cnt - b_we, 0);
        chk("rst_first_done_count", done_cnt - b_done, 0);
        write_frame(7'h2B, 8'h5A);
        chk("rst_second_we_count", we_cnt - b_we, 1);
        chk("rst_second_addr", we_addr, 7'h2B);
        chk("rst_second_data", we_data, 8'h5A);

        // back-to-back writes
        snap();
        write_frame(7'h10, 8'h11);
        write_frame(7'h11, 8'h22);
        chk("b2b_we_count", we_cnt - b_we, 2);
        chk("b2b_done_count", done_cnt - b_done, 2);
        chk("b2b_first", we_log[we_log.size() - 2], {7'h10, 8'h11});
        chk("b2b_second", we_log[we_log.size() - 1], {7'h11, 8'h22});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 7, memory address bits per frame.
- DATA_WIDTH, 8, data bits per frame.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single system clock.
- reset_n, in, 1, asynchronous active-low reset.
- SCL, in, 1, serial clock from the i2c master.
- SDA_OUT, in, 1, serial data from the i2c master.
- ack_n, out, 1, active-low acknowledge back to the master.
- mem_addr, out, ADDR_WIDTH, memory address.
- mem_wdata, out, DATA_WIDTH, memory write data.
- mem_we, out, 1, one-cycle write strobe.
- mem_re, out, 1, one-cycle read strobe.
- mem_rdata, in, DATA_WIDTH, read data, valid exactly one clk after mem_re.
- data_out, out, DATA_WIDTH, last read result.
- done, out, 1, one-cycle transaction-complete pulse.

Function
REQ-003 SCL and SDA_OUT SHALL each pass through a 2-flop synchronizer; all decoding SHALL use only the synchronized values (sSCL, sSDA).

REQ-004 Edge and condition detection:
- START = sSDA falls while sSCL is high in both the current and previous cycle.
- STOP = sSDA rises under the same sSCL condition.
- Bit sample = sSDA captured on the cycle sSCL rises.

REQ-005 The frame SHALL be: START, ADDR_WIDTH address bits MSB first, one R_W bit (1 = read), ACK slot; for writes, DATA_WIDTH data bits MSB first, then an ACK slot.

REQ-006 FSM states SHALL be IDLE, ADDR, ACK_A, DATA, ACK_D, EXEC, RDWAIT.
- IDLE -> ADDR on START.
- ADDR -> ACK_A after the 8th sampled bit.
- ACK_A -> DATA (write) or EXEC (read) on the sSCL falling edge that ends the ACK slot.
- DATA -> ACK_D after DATA_WIDTH sampled bits.
- ACK_D -> EXEC at the end of the ACK slot.
- EXEC -> IDLE (write) or RDWAIT (read) after one cycle.
- RDWAIT -> IDLE after one cycle.

REQ-007 A 4-bit bit counter SHALL clear on entry to ADDR and DATA, and increment on each bit sample.

REQ-008 ack_n SHALL go low the clk after the sSCL falling edge that follows the final bit of a byte, and return high the clk after the next sSCL falling edge.

REQ-009 In EXEC, mem_addr SHALL hold the received address, and exactly one of mem_we or mem_re SHALL be high for exactly one cycle; mem_wdata SHALL hold the received byte when mem_we is high.

REQ-010 Write completion: done SHALL pulse in the cycle after the mem_we cycle.

REQ-011 Read completion: in RDWAIT, data_out SHALL load mem_rdata and done SHALL pulse in that same cycle; data_out SHALL hold its value until the next read.

REQ-012 A STOP in any state other than IDLE, EXEC or RDWAIT SHALL abort to IDLE: no mem strobe, no done, and ack_n forced high.

REQ-013 A START (repeated START) in any state other than EXEC or RDWAIT SHALL restart ADDR with the counter cleared and the partial frame discarded.

REQ-014 START and STOP seen during EXEC or RDWAIT SHALL take effect only after return to IDLE; a START in that window SHALL be latched and applied in IDLE.

REQ-015 Read-path end condition: STOP after the ACK slot of a read frame SHALL be a legal end of frame.

REQ-016 Write-path end condition: STOP after ACK_D SHALL be a legal end of frame.

Reset
REQ-017 On reset_n low, asynchronously:
- FSM -> IDLE.
- Synchronizers -> 1.
- ack_n = 1, mem_we = 0, mem_re = 0, done = 0.
- mem_addr = 0, mem_wdata = 0, data_out = 0, bit counter = 0.

REQ-018 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh START.

Structure
REQ-019 Package i2c_rx_pkg SHALL hold the FSM state enum, the ADDR_WIDTH/DATA_WIDTH defaults and the bit-counter width constant.

REQ-020 Sub-module i2c_sync_edge SHALL implement the 2-flop synchronizer plus rise/fall detect; it SHALL be instantiated once per serial line.

Verification
REQ-021 Write: START, addr 7'h15, R_W = 0, data 8'hA5, STOP -> ack_n low in both ACK slots; one mem_we with mem_addr = 7'h15 and mem_wdata = 8'hA5; done one cycle later.

REQ-022 Read: START, addr 7'h7F, R_W = 1, memory returns 8'h3C -> one mem_re with mem_addr = 7'h7F; data_out = 8'h3C; done pulses once.

REQ-023 Abort: STOP after 4 data bits of a write to 7'h01 -> no mem_we, no done, ack_n high, FSM in IDLE.

REQ-024 Repeated START after 5 address bits, then a full write of 8'hFF to 7'h00 -> a single mem_we with addr 7'h00 and data 8'hFF.

REQ-025 Reset pulse mid-DATA, then a full write of 8'h5A to 7'h2B -> all outputs at reset values during reset; the first frame produces no access; the second frame writes correctly.

REQ-026 Back-to-back: two writes (7'h10 <- 8'h11, 7'h11 <- 8'h22) separated by STOP/START -> two mem_we pulses, two done pulses, in order.
